// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control path.
// Holds the FSM state encoding and header address parameters.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm_if.sv
// Signal bundle between the router FSM and its neighbours.
// master: source/synchroniser/register side; slave: the FSM.
interface router_fsm_if;
    import router_pkg::*;

    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic              fifo_full;
    logic              fifo_empty_0;
    logic              fifo_empty_1;
    logic              fifo_empty_2;
    logic              soft_reset_0;
    logic              soft_reset_1;
    logic              soft_reset_2;
    logic              parity_done;
    logic              low_packet_valid;

    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              write_enb_reg;
    logic              busy;
    logic [ADDR_W-1:0] addr_q;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_packet_valid,
        input  detect_add, lfd_state, ld_state, laf_state,
        input  full_state, rst_int_reg, write_enb_reg, busy,
        input  addr_q
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_packet_valid,
        output detect_add, lfd_state, ld_state, laf_state,
        output full_state, rst_int_reg, write_enb_reg, busy,
        output addr_q
    );

endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes header address and sequences header,
// payload, parity and FIFO-full recovery. Ports: clock, resetn
// (sync, active-low) and bus (slave side of router_fsm_if).
module router_fsm
    import router_pkg::*;
(
    input  logic         clock,
    input  logic         resetn,
    router_fsm_if.slave  bus
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] addr_r;
    logic              empty_in;
    logic              empty_q;
    logic              sr_q;
    logic              hdr_ok;

    // Empty flag of the port named by the incoming header
    always_comb begin
        empty_in = 1'b0;
        case (bus.data_in)
            2'd0:    empty_in = bus.fifo_empty_0;
            2'd1:    empty_in = bus.fifo_empty_1;
            2'd2:    empty_in = bus.fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
    end

    // Empty flag and soft reset of the latched destination
    always_comb begin
        empty_q = 1'b0;
        sr_q    = 1'b0;
        case (addr_r)
            2'd0: begin
                empty_q = bus.fifo_empty_0;
                sr_q    = bus.soft_reset_0;
            end
            2'd1: begin
                empty_q = bus.fifo_empty_1;
                sr_q    = bus.soft_reset_1;
            end
            2'd2: begin
                empty_q = bus.fifo_empty_2;
                sr_q    = bus.soft_reset_2;
            end
            default: begin
                empty_q = 1'b0;
                sr_q    = 1'b0;
            end
        endcase
    end

    assign hdr_ok = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state  <= DECODE_ADDRESS;
            addr_r <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_r <= bus.data_in;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS:
                if (hdr_ok)
                    next_state = empty_in ? LOAD_FIRST_DATA
                                          : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:
                if (empty_q)
                    next_state = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:
                next_state = LOAD_DATA;
            LOAD_DATA:
                if (bus.fifo_full)
                    next_state = FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    next_state = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!bus.fifo_full)
                    next_state = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (bus.parity_done)
                    next_state = DECODE_ADDRESS;
                else if (bus.low_packet_valid)
                    next_state = LOAD_PARITY;
                else
                    next_state = LOAD_DATA;
            LOAD_PARITY:
                next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                next_state = bus.fifo_full ? FIFO_FULL_STATE
                                           : DECODE_ADDRESS;
            default:
                next_state = DECODE_ADDRESS;
        endcase
        // Read-timeout on the selected port abandons the packet
        if (state != DECODE_ADDRESS && sr_q)
            next_state = DECODE_ADDRESS;
    end

    assign bus.detect_add  = (state == DECODE_ADDRESS);
    assign bus.lfd_state   = (state == LOAD_FIRST_DATA);
    assign bus.ld_state    = (state == LOAD_DATA);
    assign bus.laf_state   = (state == LOAD_AFTER_FULL);
    assign bus.full_state  = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg = (state == CHECK_PARITY_ERROR);

    assign bus.write_enb_reg = (state == LOAD_DATA)
                             | (state == LOAD_PARITY)
                             | (state == LOAD_AFTER_FULL);

    assign bus.busy = (state != DECODE_ADDRESS)
                   && (state != LOAD_DATA);

    assign bus.addr_q = addr_r;

endmodule
